// File: rtl/pixel_write_arbiter_if.sv
// Handshake bundle between the drawing engines, the pixel write arbiter and the
// SDRAM pixel-buffer Avalon slave. "master" is the arbiter side, "slave" the environment.
interface pixel_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16
) ();
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;

  logic [ADDR_W-1:0]         avm_address;
  logic [DATA_W-1:0]         avm_writedata;
  logic                      avm_write;
  logic                      avm_waitrequest;

  logic [GID_W-1:0]          grant_id;
  logic                      busy;
  logic [31:0]               beat_count;

  modport master (
    input  req_valid, req_addr, req_data, req_lock, avm_waitrequest,
    output req_ready, avm_address, avm_writedata, avm_write, grant_id, busy, beat_count
  );

  modport slave (
    output req_valid, req_addr, req_data, req_lock, avm_waitrequest,
    input  req_ready, avm_address, avm_writedata, avm_write, grant_id, busy, beat_count
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter serialising single-pixel engine writes onto one registered
// Avalon-MM write stream. Optional grant locking is built with PIXEL_ARB_LOCK_EN.
module pixel_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_write_arbiter_if.master bus
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [GID_W-1:0]    grant_q, grant_d;
  logic [GID_W-1:0]    ptr_q, ptr_d;
  logic [31:0]         beat_count_q, beat_count_d;

  logic [GID_W-1:0]    cand;
  logic                cand_valid;
  logic                slot_free;
  logic                accept;

  function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

`ifdef PIXEL_ARB_LOCK_EN
  localparam int LCNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic                locked_q, locked_d;
  logic [GID_W-1:0]    owner_q, owner_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
  assign unused_lock = ^bus.req_lock;
`endif

  assign slot_free = (state_q == IDLE) || !bus.avm_waitrequest;
  assign accept    = cand_valid && slot_free;

  // Search downward so the index closest to ptr is the last, winning assignment.
  always_comb begin
    logic [GID_W-1:0] j;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cand       = '0;
    cand_valid = 1'b0;
    j          = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = GID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[j]) begin
        cand       = j;
        cand_valid = 1'b1;
      end
    end
`ifdef PIXEL_ARB_LOCK_EN
    if (locked_q) begin
      cand       = owner_q;
      cand_valid = bus.req_valid[owner_q];
    end
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[cand] = 1'b1;
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (!bus.avm_waitrequest && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.avm_write = 1'b0;
    bus.busy      = 1'b0;
    if (state_q == ISSUE) begin
      bus.avm_write = 1'b1;
      bus.busy      = 1'b1;
    end
  end

  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    beat_count_d = beat_count_q;
    if (state_q == ISSUE && !bus.avm_waitrequest) beat_count_d = beat_count_q + 32'd1;
    if (accept) begin
      addr_d  = bus.req_addr[cand*ADDR_W +: ADDR_W];
      data_d  = bus.req_data[cand*DATA_W +: DATA_W];
      grant_d = cand;
      ptr_d   = next_idx(cand);
    end
`ifdef PIXEL_ARB_LOCK_EN
    locked_d   = locked_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      locked_d   = bus.req_lock[cand];
      owner_d    = cand;
      lock_cnt_d = '0;
      // A held lock keeps ptr where it was; a releasing beat still advances it.
      if (locked_q && bus.req_lock[cand]) ptr_d = ptr_q;
    end else if (locked_q && slot_free && !bus.req_valid[owner_q]) begin
      if (lock_cnt_q == LCNT_W'(LOCK_TIMEOUT - 1)) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        ptr_d      = next_idx(owner_q);
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      ptr_q        <= '0;
      beat_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      beat_count_q <= beat_count_d;
    end
  end

`ifdef PIXEL_ARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q   <= 1'b0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      locked_q   <= locked_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = data_q;
  assign bus.grant_id      = grant_q;
  assign bus.beat_count    = beat_count_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus random
// traffic against a transaction-level round-robin reference model.
module tb_pixel_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  pixel_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            id;
  } beat_t;

  // Stimulus: one pending offer per requester, held until accepted.
  logic          off_v [N];
  logic [AW-1:0] off_a [N];
  logic [DW-1:0] off_d [N];
  logic          off_l [N];
  logic          wr;

  // Reference model state.
  beat_t       cur;
  bit          m_busy;
  int          m_ptr;
  logic [31:0] m_count;
  int          m_owner;
  int          m_idle;
  bit          last_accept;
  int          last_grant;

  // Values observed at the last sampling point.
  logic [N-1:0]  obs_ready;
  logic          obs_write;
  logic [1:0]    obs_grant;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic [31:0]   obs_count;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = off_v[i];
      bus.req_addr[i*AW +: AW]    = off_a[i];
      bus.req_data[i*DW +: DW]    = off_d[i];
      bus.req_lock[i]             = off_l[i];
    end
    bus.avm_waitrequest = wr;
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_ptr   = 0;
    m_count = '0;
    m_owner = -1;
    m_idle  = 0;
  endtask

  task automatic rearm(input int i, input logic lk);
    off_v[i] = 1'b1;
    off_a[i] = $urandom;
    off_d[i] = 16'($urandom);
    off_l[i] = lk;
  endtask

  function automatic int pick();
    if (m_owner >= 0) return off_v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (off_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock: drive after the edge, sample and check at the falling edge,
  // advance the model to the post-edge state.
  task automatic cycle();
    int c;
    bit sf;
    logic [N-1:0] exp_ready;
    drive();
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_write = bus.avm_write;
    obs_grant = bus.grant_id;
    obs_addr  = bus.avm_address;
    obs_data  = bus.avm_writedata;
    obs_count = bus.beat_count;
    check("avm_write", obs_write, m_busy);
    check("busy", bus.busy, m_busy);
    check("beat_count", obs_count, m_count);
    if (m_busy) begin
      check("avm_address", obs_addr, cur.a);
      check("avm_writedata", obs_data, cur.d);
      check("grant_id", obs_grant, cur.id);
    end
    sf = !m_busy || !wr;
    c  = pick();
    exp_ready = '0;
    if (sf && c >= 0) exp_ready[c] = 1'b1;
    check("req_ready", obs_ready, exp_ready);
    last_accept = 0;
    if (m_busy && !wr) begin
      m_count++;
      m_busy = 0;
    end
    if (sf && c >= 0) begin
      cur         = '{off_a[c], off_d[c], c};
      m_busy      = 1;
      m_ptr       = (c + 1) % N;
      last_accept = 1;
      last_grant  = c;
      off_v[c]    = 1'b0;
`ifdef PIXEL_ARB_LOCK_EN
      m_owner = off_l[c] ? c : -1;
      m_idle  = 0;
    end else if (m_owner >= 0 && sf && !off_v[m_owner]) begin
      m_idle++;
      if (m_idle == LT) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_idle  = 0;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b0;
      off_l[i] = 1'b0;
      off_a[i] = '0;
      off_d[i] = '0;
    end
    wr = 1'b0;
    drive();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_write", bus.avm_write, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_address", bus.avm_address, '0);
    check("rst_writedata", bus.avm_writedata, '0);
    check("rst_grant", bus.grant_id, '0);
    check("rst_count", bus.beat_count, '0);
    check("rst_ready", bus.req_ready, '0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;

    // Single requester 2, ptr at 0.
    do_reset();
    rearm(2, 1'b0);
    a1 = off_a[2];
    cycle();
    check("single_ready", obs_ready, 4'b0100);
    cycle();
    check("single_write", obs_write, 1'b1);
    check("single_grant", obs_grant, 2'd2);
    check("single_addr", obs_addr, a1);
    cycle();
    check("single_count", obs_count, 32'd1);
    check("single_idle", obs_write, 1'b0);

    // All four valid continuously.
    do_reset();
    for (int i = 0; i < N; i++) rearm(i, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k >= 1 && k <= 5) begin
        check($sformatf("rr_grant%0d", k), obs_grant, exp_g[k-1]);
        check($sformatf("rr_write%0d", k), obs_write, 1'b1);
      end
      if (last_accept) rearm(last_grant, 1'b0);
    end
    check("rr_count", obs_count, 32'd5);
    for (int i = 0; i < N; i++) off_v[i] = 1'b0;
    cycle();
    cycle();

    // Three-cycle waitrequest stall.
    do_reset();
    rearm(1, 1'b0);
    rearm(3, 1'b0);
    a1 = off_a[1];
    d1 = off_d[1];
    cycle();
    check("stall_first", obs_ready, 4'b0010);
    wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("stall_ready%0d", k), obs_ready, '0);
      check($sformatf("stall_addr%0d", k), obs_addr, a1);
      check($sformatf("stall_data%0d", k), obs_data, d1);
      check($sformatf("stall_write%0d", k), obs_write, 1'b1);
    end
    wr = 1'b0;
    cycle();
    check("release_addr", obs_addr, a1);
    check("release_ready", obs_ready, 4'b1000);
    cycle();
    check("release_grant", obs_grant, 2'd3);
    cycle();

    // Asynchronous reset while a stalled beat is on the bus.
    do_reset();
    rearm(0, 1'b0);
    rearm(1, 1'b0);
    cycle();
    cycle();
    wr = 1'b1;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async_write", bus.avm_write, 1'b0);
    check("async_count", bus.beat_count, '0);
    check("async_busy", bus.busy, 1'b0);
    do_reset();
    rearm(1, 1'b0);
    rearm(3, 1'b0);
    cycle();
    check("post_reset_ready", obs_ready, 4'b0010);
    off_v[3] = 1'b0;
    cycle();
    cycle();

`ifdef PIXEL_ARB_LOCK_EN
    begin
      logic [N-1:0] lk_exp [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
      logic [N-1:0] to_exp [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      logic lk_seq [3] = '{1'b1, 1'b1, 1'b0};
      do_reset();
      rearm(0, 1'b0);
      cycle();
      rearm(0, 1'b0);
      rearm(2, 1'b0);
      rearm(1, lk_seq[0]);
      for (int k = 0; k < 5; k++) begin
        cycle();
        check($sformatf("lock_ready%0d", k), obs_ready, lk_exp[k]);
        if (k < 2) rearm(1, lk_seq[k+1]);
      end
      cycle();
      cycle();

      do_reset();
      rearm(1, 1'b1);
      cycle();
      rearm(3, 1'b0);
      for (int k = 0; k < 5; k++) begin
        cycle();
        check($sformatf("timeout_ready%0d", k), obs_ready, to_exp[k]);
      end
      cycle();
      cycle();
    end
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        if (!off_v[i] && $urandom_range(0, 2) == 0) rearm(i, ($urandom_range(0, 3) == 0));
      wr = ($urandom_range(0, 3) == 0);
      cycle();
    end
    for (int i = 0; i < N; i++) off_v[i] = 1'b0;
    wr = 1'b0;
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
Round-robin arbiter that shares the single Avalon-MM write master into the SDRAM pixel buffer among NUM_REQ drawing engines (ball, background and overlay renderers). Each engine offers single-pixel writes over a valid/ready handshake. The arbiter serialises them into one registered Avalon write stream and honours waitrequest. It sits between the engines and the Computer_System SDRAM/pixel-buffer slave port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, byte address width of the pixel buffer
DATA_W, 16, pixel colour width (RGB565)
LOCK_TIMEOUT, 64, max idle cycles a lock may hold the grant (only with PIXEL_ARB_LOCK_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write offer
req_ready  out  NUM_REQ  per-requester accept (combinational)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed pixel data, same packing
req_lock  in  NUM_REQ  keep grant after this beat (used only with PIXEL_ARB_LOCK_EN)
avm_address  out  ADDR_W  Avalon address (registered)
avm_writedata  out  DATA_W  Avalon write data (registered)
avm_write  out  1  Avalon write strobe (registered)
avm_waitrequest  in  1  Avalon slave stall
grant_id  out  clog2(NUM_REQ)  index of the requester owning the current/last beat
busy  out  1  high whenever avm_write is high
beat_count  out  32  total completed Avalon writes, wraps 0xFFFFFFFF->0

Behaviour:
- States: IDLE (avm_write=0), ISSUE (avm_write=1). slot_free = IDLE or (ISSUE and !avm_waitrequest).
- Arbitration is combinational. Candidate = first i with req_valid[i], searching from ptr upward modulo NUM_REQ. req_ready[candidate] = slot_free; all other ready bits = 0. At most one ready bit is high.
- Accept = valid&ready at a clock edge. On accept: latch addr/data into avm_*, set avm_write=1, grant_id=i, ptr=(i+1) mod NUM_REQ, next state ISSUE. Latency from accept edge to avm_write high = 1 cycle.
- ISSUE with waitrequest=1: avm_address, avm_writedata and avm_write are held stable. No ready is asserted.
- ISSUE with waitrequest=0: the beat completes and beat_count increments. If a new accept occurs in the same cycle, stay in ISSUE with the new beat, back-to-back, for 1 beat/cycle throughput. Otherwise go to IDLE and clear avm_write.
- Requesters must hold valid, addr and data stable until accepted. The arbiter never drops or duplicates a beat.
- No valid requests while slot_free: no state change, ptr unchanged.
- Reset, asynchronous and usable mid-transaction: state=IDLE, avm_write=0, avm_address=0, avm_writedata=0, grant_id=0, busy=0, beat_count=0, ptr=0, lock state cleared. Any in-flight beat is abandoned.

Optional Feature:
Macro PIXEL_ARB_LOCK_EN.
- Defined: if an accepted beat had req_lock[i]=1, the arbiter enters a locked state for requester i. While locked, only i can be granted, and ptr is not advanced.
  - Lock releases when i completes a beat with req_lock=0.
  - Lock also releases after LOCK_TIMEOUT consecutive slot_free cycles with req_valid[i]=0; the counter resets on each accept from i.
  - On release, ptr=(i+1) mod NUM_REQ.
- Not defined: req_lock is ignored, no lock logic or timeout counter is built, and arbitration is pure round-robin.

Test Plan:
- Single requester 2 valid at ptr=0, waitrequest=0 -> req_ready[2]=1 in the same cycle; next cycle avm_write=1 with addr/data of req 2, grant_id=2; beat_count=1 after completion.
- All 4 valid continuously, waitrequest=0 -> grant order 0,1,2,3,0, one beat per cycle, no gaps, beat_count=5 after 5 beats.
- Beat issued, waitrequest high for 3 cycles -> avm_* stable for 4 cycles, all req_ready=0 during stall, next accept on the release cycle.
- Reset asserted while avm_write=1 and waitrequest=1 -> avm_write=0 and beat_count=0 immediately. After release, the first grant goes to the lowest valid index from 0.
- PIXEL_ARB_LOCK_EN: req 1 sends 3 beats with lock=1,1,0 while req 0 and req 2 are valid -> the 3 beats go 1,1,1 consecutively, then grant 2 (ptr=2), then 0.
- PIXEL_ARB_LOCK_EN with LOCK_TIMEOUT=4: req 1 locks, then drops valid while req 3 is valid -> req 3 is granted on exactly the 5th slot_free cycle.
